queue_ptr_ctrl: RTL

Circular-queue pointer controller for the Gambit issue queue and reorder buffer. It generalises the per-entry head rotation to a parametrised depth, including non-power-of-two depths. It adds tail pointers, occupancy tracking, full/empty flags, branch-flush tail rollback and sticky overflow/underflow detection. One instance sits beside each of the IQ and the ROB; rename/dispatch drives enqueue, commit drives dequeue, and the branch unit drives flush.

---
 rtl/gambit_qptr_pkg.sv | 17 +
 rtl/queue_ptr_ctrl_wrap.sv | 48 ++++
 rtl/queue_ptr_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/gambit_qptr_pkg.sv
// Shared configuration for the Gambit queue pointer controllers:
// default depths and widths, and the per-queue pointer types.
package gambit_qptr_pkg;

  localparam int IQ_ENTRIES  = 16;
  localparam int RENTRIES    = 32;
  localparam int DFLT_ENQ_W  = 4;
  localparam int DFLT_DEQ_W  = 4;

  localparam int QID_W = $clog2(IQ_ENTRIES);
  localparam int RID_W = $clog2(RENTRIES);

  // Issue-queue slot index and reorder-buffer slot index.
  typedef logic [QID_W-1:0] qid_t;
  typedef logic [RID_W-1:0] rid_t;

endpackage

// File: rtl/queue_ptr_ctrl_wrap.sv
// Modular pointer arithmetic for circular queues of arbitrary depth.
// Both helpers avoid '%' so that non-power-of-two depths stay cheap.

// s = (p + a) mod ENTRIES, valid for p < ENTRIES and a <= ENTRIES.
module ptr_wrap_add #(
  parameter int ENTRIES = 16,
  parameter int PW      = $clog2(ENTRIES),
  parameter int AW      = PW + 1
) (
  input  logic [PW-1:0] p_i,
  input  logic [AW-1:0] a_i,
  output logic [PW-1:0] s_o
);
  localparam int SW = PW + 1;

  logic [SW-1:0] sum_s;

  // One conditional subtract folds the sum back into 0..ENTRIES-1.
  always_comb begin
    sum_s = SW'(p_i) + SW'(a_i);
    if (sum_s >= SW'(ENTRIES)) begin
      s_o = PW'(sum_s - SW'(ENTRIES));
    end else begin
      s_o = PW'(sum_s);
    end
  end
endmodule

// d = (a - b) mod ENTRIES, valid for a, b < ENTRIES.
module ptr_wrap_sub #(
  parameter int ENTRIES = 16,
  parameter int PW      = $clog2(ENTRIES)
) (
  input  logic [PW-1:0] a_i,
  input  logic [PW-1:0] b_i,
  output logic [PW-1:0] d_o
);
  localparam int SW = PW + 1;

  // Borrow across the wrap point by adding the depth back in.
  always_comb begin
    if (a_i >= b_i) begin
      d_o = a_i - b_i;
    end else begin
      d_o = PW'(SW'(a_i) + SW'(ENTRIES) - SW'(b_i));
    end
  end
endmodule

// File: rtl/queue_ptr_ctrl.sv
// Circular-queue pointer controller: head/tail pointers, occupancy,
// full/empty, flush-time tail rollback and sticky request-error flags.
// Every output is a register loaded from next-state values.
module queue_ptr_ctrl
  import gambit_qptr_pkg::*;
#(
  parameter int ENTRIES = IQ_ENTRIES,
  parameter int PW      = $clog2(ENTRIES),
  parameter int ENQ_W   = DFLT_ENQ_W,
  parameter int DEQ_W   = DFLT_DEQ_W,
  parameter int CNT_W   = 32,
  localparam int EAW    = $clog2(ENQ_W + 1),
  localparam int DAW    = $clog2(DEQ_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [EAW-1:0]              enq_amt,
  input  logic [DAW-1:0]              deq_amt,
  input  logic                        flush,
  input  logic [PW-1:0]               flush_tail,
  output logic [DEQ_W-1:0][PW-1:0]    heads,
  output logic [ENQ_W-1:0][PW-1:0]    tails,
  output logic [PW:0]                 count,
  output logic [PW:0]                 free_cnt,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            retired,
  output logic                        err_ovf,
  output logic                        err_udf
);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_adv_s, tail_adv_s, flush_cnt_s;
  logic [PW:0]   count_d, enq_ext_s, deq_ext_s;
  logic          deq_ok_s, enq_fit_s, enq_ok_s;
  logic [DEQ_W-1:0][PW-1:0] heads_nx_s;
  logic [ENQ_W-1:0][PW-1:0] tails_nx_s;

  ptr_wrap_add #(.ENTRIES(ENTRIES), .PW(PW), .AW(DAW)) u_head_adv (
    .p_i(head_q), .a_i(deq_amt), .s_o(head_adv_s)
  );

  ptr_wrap_add #(.ENTRIES(ENTRIES), .PW(PW), .AW(EAW)) u_tail_adv (
    .p_i(tail_q), .a_i(enq_amt), .s_o(tail_adv_s)
  );

  // Occupancy after flush is measured from the post-commit head.
  ptr_wrap_sub #(.ENTRIES(ENTRIES), .PW(PW)) u_flush_cnt (
    .a_i(flush_tail), .b_i(head_d), .d_o(flush_cnt_s)
  );

  for (genvar i = 0; i < DEQ_W; i++) begin : g_heads
    ptr_wrap_add #(.ENTRIES(ENTRIES), .PW(PW), .AW(PW + 1)) u_off (
      .p_i(head_d), .a_i((PW + 1)'(i)), .s_o(heads_nx_s[i])
    );
  end

  for (genvar i = 0; i < ENQ_W; i++) begin : g_tails
    ptr_wrap_add #(.ENTRIES(ENTRIES), .PW(PW), .AW(PW + 1)) u_off (
      .p_i(tail_d), .a_i((PW + 1)'(i)), .s_o(tails_nx_s[i])
    );
  end

  // Commit side: accept a dequeue only if that many entries are occupied.
  always_comb begin
    deq_ext_s = (PW + 1)'(deq_amt);
    deq_ok_s  = (deq_ext_s <= count);
    if (deq_ok_s) begin
      head_d = head_adv_s;
    end else begin
      head_d = head_q;
    end
  end

  // Allocation side: flush rolls the tail back, otherwise enqueue against
  // last cycle's free count (same-cycle commits do not free slots early).
  always_comb begin
    enq_ext_s = (PW + 1)'(enq_amt);
    enq_fit_s = (enq_ext_s <= free_cnt);
    enq_ok_s  = !flush && enq_fit_s;
    if (flush) begin
      tail_d  = flush_tail;
      count_d = {1'b0, flush_cnt_s};
    end else begin
      tail_d  = enq_ok_s ? tail_adv_s : tail_q;
      count_d = count + (enq_ok_s ? enq_ext_s : {(PW + 1){1'b0}})
                      - (deq_ok_s ? deq_ext_s : {(PW + 1){1'b0}});
    end
  end

  // State and registered status; reset wins over every request.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= {PW{1'b0}};
      tail_q   <= {PW{1'b0}};
      count    <= {(PW + 1){1'b0}};
      free_cnt <= (PW + 1)'(ENTRIES);
      full     <= 1'b0;
      empty    <= 1'b1;
      retired  <= {CNT_W{1'b0}};
      err_ovf  <= 1'b0;
      err_udf  <= 1'b0;
      for (int i = 0; i < DEQ_W; i++) heads[i] <= PW'(i);
      for (int i = 0; i < ENQ_W; i++) tails[i] <= PW'(i);
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count    <= count_d;
      free_cnt <= (PW + 1)'(ENTRIES) - count_d;
      full     <= (count_d == (PW + 1)'(ENTRIES));
      empty    <= (count_d == {(PW + 1){1'b0}});
      retired  <= retired + (deq_ok_s ? CNT_W'(deq_amt) : {CNT_W{1'b0}});
      err_ovf  <= err_ovf | (!flush && !enq_fit_s);
      err_udf  <= err_udf | !deq_ok_s;
      heads    <= heads_nx_s;
      tails    <= tails_nx_s;
    end
  end

endmodule
